// File: rtl/oq_pkg.sv
// Shared definitions for the SRAM output-queue memory word format and
// the unpacker state machine.
package oq_pkg;

    localparam int PAYLOAD_LSB = 10;
    localparam int BYTES_MSB   = 9;
    localparam int BYTES_LSB   = 5;
    localparam int KIND_MSB    = 4;
    localparam int KIND_LSB    = 2;
    localparam int LAST_BIT    = 1;
    localparam int LANE_BITS   = 64;

    localparam logic [KIND_MSB-KIND_LSB:0] KIND_HDR = '0;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        DATA  = 2'd1,
        FLUSH = 2'd2
    } oq_state_e;

endpackage

// File: rtl/oq_lane_accumulator.sv
// Merge/shift datapath: packs memory payloads into 64-bit lanes and
// exposes the low DATA_WIDTH bits of the post-merge view as the next beat.
module oq_lane_accumulator
    import oq_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int MEM_PAYLOAD = 192,
    parameter int CNT_W       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic                   shift,
    input  logic                   clear,
    input  logic [MEM_PAYLOAD-1:0] payload,
    output logic [DATA_WIDTH-1:0]  beat,
    output logic [CNT_W-1:0]       cnt,
    output logic [CNT_W-1:0]       merged_cnt
);

    localparam int ACC_W      = DATA_WIDTH + MEM_PAYLOAD;
    localparam int DATA_LANES = DATA_WIDTH / LANE_BITS;
    localparam int WORD_LANES = MEM_PAYLOAD / LANE_BITS;

    logic [ACC_W-1:0] acc_q, acc_d, acc_m;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_m;
    logic [CNT_W+5:0] lane_base;

    // acc_m is the view after this cycle's write, so a beat can leave in
    // the same cycle the completing word is consumed.
    always_comb begin
        acc_m     = acc_q;
        cnt_m     = cnt_q;
        lane_base = {cnt_q, 6'd0};
        if (wr) begin
            acc_m[lane_base +: MEM_PAYLOAD] = payload;
            cnt_m = cnt_q + CNT_W'(WORD_LANES);
        end
        acc_d = acc_m;
        cnt_d = cnt_m;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (shift) begin
            acc_d = acc_m >> DATA_WIDTH;
            cnt_d = cnt_m - CNT_W'(DATA_LANES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign beat       = acc_m[DATA_WIDTH-1:0];
    assign cnt        = cnt_q;
    assign merged_cnt = cnt_m;

endmodule

// File: rtl/oq_mem_unpacker.sv
// Rebuilds an AXI4-Stream packet from packed output-queue memory words,
// with residue flushing, malformed-packet recovery and statistics.
module oq_mem_unpacker
    import oq_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128,
    parameter int MEM_PAYLOAD = 192,
    parameter int MEM_WIDTH   = MEM_PAYLOAD + 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [MEM_WIDTH-1:0]    din,
    input  logic                    empty,
    output logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [31:0]             pkt_count,
    output logic [15:0]             err_count
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int PAY_BYTES  = MEM_PAYLOAD / 8;
    localparam int DATA_LANES = DATA_WIDTH / LANE_BITS;
    localparam int CNT_W      = $clog2((DATA_WIDTH + MEM_PAYLOAD) / LANE_BITS + 1);

    function automatic logic [DATA_BYTES-1:0] strb_for(input logic [15:0] nbytes);
        logic [DATA_BYTES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < DATA_BYTES; i++)
            if (16'(i) < nbytes) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mask_bytes(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [DATA_BYTES-1:0] s);
        logic [DATA_WIDTH-1:0] r;
        for (int unsigned i = 0; i < DATA_BYTES; i++)
            r[i*8 +: 8] = s[i] ? d[i*8 +: 8] : 8'h00;
        return r;
    endfunction

    oq_state_e state_q, state_d;
    logic [TUSER_WIDTH-1:0] hdr_user_q, hdr_user_d;
    logic                   first_q, first_d;
    logic [15:0]            res_bytes_q, res_bytes_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
    logic [DATA_BYTES-1:0]  tstrb_q, tstrb_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;
    logic [31:0]            pkt_q, pkt_d;
    logic [15:0]            err_q, err_d;

    logic [MEM_PAYLOAD-1:0]       w_payload;
    logic [BYTES_MSB-BYTES_LSB:0] w_bytes;
    logic                         w_last, is_hdr;
    logic                         out_free, head_avail, pop;
    logic                         acc_wr, acc_shift, acc_clear;
    logic [DATA_WIDTH-1:0]        acc_beat;
    logic [CNT_W-1:0]             acc_cnt, acc_mcnt;
    logic                         emit, emit_last, pkt_inc, err_inc;
    logic [DATA_BYTES-1:0]        emit_strb;
    logic [15:0]                  word_bytes, rem;
    logic                         unused_din;

    assign w_payload  = din[MEM_WIDTH-1:PAYLOAD_LSB];
    assign w_bytes    = din[BYTES_MSB:BYTES_LSB];
    assign w_last     = din[LAST_BIT];
    assign is_hdr     = (din[KIND_MSB:KIND_LSB] == KIND_HDR);
    assign unused_din = din[0];

    oq_lane_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_PAYLOAD(MEM_PAYLOAD),
        .CNT_W      (CNT_W)
    ) u_acc (
        .clk       (clk),
        .reset     (reset),
        .wr        (acc_wr),
        .shift     (acc_shift),
        .clear     (acc_clear),
        .payload   (w_payload),
        .beat      (acc_beat),
        .cnt       (acc_cnt),
        .merged_cnt(acc_mcnt)
    );

    always_comb begin
        out_free   = !tvalid_q || m_axis_tready;
        head_avail = !empty && !reset && out_free;
        // A header seen in DATA stays in the FIFO; it starts the next packet.
        pop        = head_avail && (state_q == HDR || (state_q == DATA && !is_hdr));
        word_bytes = (w_bytes == '0) ? 16'(PAY_BYTES) : 16'(w_bytes);
        rem        = 16'(acc_cnt) * 16'd8 + word_bytes;

        state_d     = state_q;
        hdr_user_d  = hdr_user_q;
        first_d     = first_q;
        res_bytes_d = res_bytes_q;
        acc_wr      = 1'b0;
        acc_shift   = 1'b0;
        acc_clear   = 1'b0;
        emit        = 1'b0;
        emit_last   = 1'b0;
        emit_strb   = '0;
        pkt_inc     = 1'b0;
        err_inc     = 1'b0;

        case (state_q)
            HDR: begin
                if (pop) begin
                    if (is_hdr && !w_last) begin
                        hdr_user_d = w_payload[TUSER_WIDTH-1:0];
                        first_d    = 1'b1;
                        state_d    = DATA;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (head_avail) begin
                    if (is_hdr) begin
                        err_inc   = 1'b1;
                        acc_clear = 1'b1;
                        state_d   = HDR;
                        if (acc_cnt != '0) begin
                            emit      = 1'b1;
                            emit_last = 1'b1;
                            emit_strb = strb_for(16'(acc_cnt) * 16'd8);
                            pkt_inc   = 1'b1;
                        end
                    end else begin
                        acc_wr = 1'b1;
                        if (!w_last) begin
                            if (acc_mcnt >= CNT_W'(DATA_LANES)) begin
                                emit      = 1'b1;
                                emit_strb = '1;
                                acc_shift = 1'b1;
                            end
                        end else if (rem <= 16'(DATA_BYTES)) begin
                            emit      = 1'b1;
                            emit_last = 1'b1;
                            emit_strb = strb_for(rem);
                            acc_clear = 1'b1;
                            pkt_inc   = 1'b1;
                            state_d   = HDR;
                        end else begin
                            emit        = 1'b1;
                            emit_strb   = '1;
                            acc_shift   = 1'b1;
                            res_bytes_d = rem - 16'(DATA_BYTES);
                            state_d     = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    emit      = 1'b1;
                    emit_last = 1'b1;
                    emit_strb = strb_for(res_bytes_q);
                    acc_clear = 1'b1;
                    pkt_inc   = 1'b1;
                    state_d   = HDR;
                end
            end
            default: state_d = HDR;
        endcase

        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tstrb_d  = tstrb_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (out_free) begin
            tvalid_d = emit;
            if (emit) begin
                tdata_d = emit_last ? mask_bytes(acc_beat, emit_strb) : acc_beat;
                tstrb_d = emit_strb;
                tlast_d = emit_last;
                tuser_d = first_q ? hdr_user_q : '0;
                first_d = 1'b0;
            end
        end

        pkt_d = pkt_inc ? pkt_q + 32'd1 : pkt_q;
        err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HDR;
            hdr_user_q  <= '0;
            first_q     <= 1'b0;
            res_bytes_q <= '0;
            tdata_q     <= '0;
            tuser_q     <= '0;
            tstrb_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            pkt_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            hdr_user_q  <= hdr_user_d;
            first_q     <= first_d;
            res_bytes_q <= res_bytes_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tstrb_q     <= tstrb_d;
            tlast_q     <= tlast_d;
            tvalid_q    <= tvalid_d;
            pkt_q       <= pkt_d;
            err_q       <= err_d;
        end
    end

    assign rd_en         = pop;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tstrb  = tstrb_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign pkt_count     = pkt_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_oq_mem_unpacker.sv
// Directed bench for oq_mem_unpacker: FIFO model in front, byte-stream
// reference model for the expected AXI beats.
module tb_oq_mem_unpacker;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int MP = 192;
    localparam int MW = 202;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [MW-1:0] din;
    logic          empty;
    logic          rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic [UW-1:0] m_axis_tuser;
    logic [31:0]   m_axis_tstrb;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [31:0]   pkt_count;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    oq_mem_unpacker #(
        .DATA_WIDTH (DW),
        .TUSER_WIDTH(UW),
        .MEM_PAYLOAD(MP),
        .MEM_WIDTH  (MW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .empty        (empty),
        .rd_en        (rd_en),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .pkt_count    (pkt_count),
        .err_count    (err_count)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [31:0]   strb;
        logic          last;
    } beat_t;

    typedef struct {
        int          nw;
        int          lb;
        int          rdy_toggle;
        int          nbeats;
        logic [31:0] lstrb;
    } vec_t;

    beat_t         beats[$];
    beat_t         exp_q[$];
    logic [MW-1:0] fifo[$];
    int            checks = 0;
    int            errors = 0;
    int            idle_nonempty = 0;
    int            pkt_exp = 0;
    logic          prev_stall = 1'b0;
    logic [289:0]  prev_snap = '0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input int id, input int k);
        return 8'((id * 37 + k * 5 + 1) % 256);
    endfunction

    function automatic logic [UW-1:0] hdr_user(input int id);
        return {4{32'hA500_0000 + 32'(id)}};
    endfunction

    task automatic drive_fifo();
        empty = (fifo.size() == 0);
        din   = empty ? '0 : fifo[0];
    endtask

    task automatic push_hdr(input int id);
        logic [MP-1:0] p;
        p = {64'hDEAD_BEEF_0000_0000 + 64'(id), hdr_user(id)};
        fifo.push_back({p, 5'd0, 3'd0, 1'b0, 1'b0});
    endtask

    task automatic push_pkt(input int id, input int nw, input int lb, input bit term);
        push_hdr(id);
        for (int w = 0; w < nw; w++) begin
            logic [MP-1:0] p;
            bit            is_last;
            int            valid;
            is_last = term && (w == nw - 1);
            valid   = (is_last && lb != 0) ? lb : 24;
            for (int b = 0; b < 24; b++)
                p[b*8 +: 8] = (b < valid) ? pbyte(id, w * 24 + b) : 8'hEE;
            fifo.push_back({p, is_last ? 5'(lb) : 5'd9, 3'd1, is_last, 1'b0});
        end
    endtask

    task automatic exp_pkt(input int id, input int len);
        int nb;
        nb = (len + 31) / 32;
        for (int i = 0; i < nb; i++) begin
            beat_t e;
            e.data = '0;
            e.strb = '0;
            for (int j = 0; j < 32; j++) begin
                if (i * 32 + j < len) begin
                    e.data[j*8 +: 8] = pbyte(id, i * 32 + j);
                    e.strb[j] = 1'b1;
                end
            end
            e.last = (i == nb - 1);
            e.user = (i == 0) ? hdr_user(id) : '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        logic  rd_s;
        beat_t b;
        @(negedge clk);
        if (prev_stall)
            chk("stall_hold", 512'({m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata}),
                512'(prev_snap));
        if (m_axis_tvalid && !m_axis_tready)
            chk("stall_no_pop", 512'(rd_en), 512'(0));
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_snap  = {m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata};
        if (fifo.size() != 0 && !rd_en) idle_nonempty++;
        if (m_axis_tvalid && m_axis_tready) begin
            b.data = m_axis_tdata;
            b.user = m_axis_tuser;
            b.strb = m_axis_tstrb;
            b.last = m_axis_tlast;
            beats.push_back(b);
        end
        rd_s = rd_en;
        @(posedge clk);
        #1;
        if (rd_s && fifo.size() != 0) fifo.delete(0);
        drive_fifo();
    endtask

    task automatic drain(input string name, input bit toggle);
        int n;
        n = 0;
        while ((fifo.size() != 0 || beats.size() < exp_q.size()) && n < 400) begin
            if (toggle) m_axis_tready = ~m_axis_tready;
            step();
            n++;
        end
        chk({name, " done"}, 512'(n < 400), 512'(1));
        m_axis_tready = 1'b1;
        repeat (4) step();
    endtask

    task automatic compare_beats(input string name);
        int n;
        chk({name, " nbeats"}, 512'(beats.size()), 512'(exp_q.size()));
        n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s b%0d data", name, i), 512'(beats[i].data), 512'(exp_q[i].data));
            chk($sformatf("%s b%0d strb", name, i), 512'(beats[i].strb), 512'(exp_q[i].strb));
            chk($sformatf("%s b%0d last", name, i), 512'(beats[i].last), 512'(exp_q[i].last));
            chk($sformatf("%s b%0d user", name, i), 512'(beats[i].user), 512'(exp_q[i].user));
        end
        beats.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, " tvalid"}, 512'(m_axis_tvalid), 512'(0));
        chk({name, " tdata"}, 512'(m_axis_tdata), 512'(0));
        chk({name, " tstrb"}, 512'(m_axis_tstrb), 512'(0));
        chk({name, " tlast"}, 512'(m_axis_tlast), 512'(0));
        chk({name, " tuser"}, 512'(m_axis_tuser), 512'(0));
        chk({name, " pkt_count"}, 512'(pkt_count), 512'(0));
        chk({name, " err_count"}, 512'(err_count), 512'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{3, 16, 0, 2, 32'hFFFF_FFFF};  // 64 bytes
        vecs[1] = '{3, 12, 0, 2, 32'h0FFF_FFFF};  // 60 bytes
        vecs[2] = '{3, 0,  0, 3, 32'h0000_00FF};  // 72 bytes, flush path
        vecs[3] = '{5, 4,  1, 4, 32'h0000_000F};  // 100 bytes, tready toggling
        vecs[4] = '{1, 8,  0, 1, 32'h0000_00FF};  // 8 bytes, single word
        vecs[5] = '{4, 8,  0, 3, 32'h0000_FFFF};  // 80 bytes
        vecs[6] = '{4, 0,  0, 3, 32'hFFFF_FFFF};  // 96 bytes, rem exactly one beat

        drive_fifo();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        chk("reset_state rd_en", 512'(rd_en), 512'(0));
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            string nm;
            int    len;
            nm  = $sformatf("vec%0d", v);
            len = 24 * (vecs[v].nw - 1) + ((vecs[v].lb == 0) ? 24 : vecs[v].lb);
            push_pkt(10 + v, vecs[v].nw, vecs[v].lb, 1'b1);
            drive_fifo();
            exp_pkt(10 + v, len);
            drain(nm, vecs[v].rdy_toggle != 0);
            chk({nm, " table_nbeats"}, 512'(beats.size()), 512'(vecs[v].nbeats));
            if (beats.size() > 0)
                chk({nm, " table_last_strb"}, 512'(beats[beats.size()-1].strb), 512'(vecs[v].lstrb));
            compare_beats(nm);
            pkt_exp++;
            chk({nm, " pkt_count"}, 512'(pkt_count), 512'(pkt_exp));
            chk({nm, " err_count"}, 512'(err_count), 512'(0));
        end

        // Back-to-back 72-byte and 64-byte packets: one FIFO-idle cycle for the flush.
        push_pkt(20, 3, 0, 1'b1);
        push_pkt(21, 3, 16, 1'b1);
        drive_fifo();
        exp_pkt(20, 72);
        exp_pkt(21, 64);
        idle_nonempty = 0;
        drain("flush_b2b", 1'b0);
        chk("flush_rd_idle_cycles", 512'(idle_nonempty), 512'(1));
        compare_beats("flush_b2b");
        pkt_exp += 2;
        chk("flush_b2b pkt_count", 512'(pkt_count), 512'(pkt_exp));

        // Stray data word while waiting for a header.
        fifo.push_back({{24{8'h5A}}, 5'd0, 3'd2, 1'b0, 1'b0});
        drive_fifo();
        repeat (3) step();
        chk("stray err_count", 512'(err_count), 512'(1));
        chk("stray no_beat", 512'(beats.size()), 512'(0));

        // Header arriving after one data word cuts the packet short.
        push_pkt(30, 1, 0, 1'b0);
        push_pkt(31, 3, 16, 1'b1);
        drive_fifo();
        exp_pkt(30, 24);
        exp_pkt(31, 64);
        drain("truncated", 1'b0);
        if (beats.size() > 0) begin
            chk("truncated residue strb", 512'(beats[0].strb), 512'(32'h00FF_FFFF));
            chk("truncated residue last", 512'(beats[0].last), 512'(1));
        end
        compare_beats("truncated");
        chk("truncated err_count", 512'(err_count), 512'(2));
        pkt_exp += 2;
        chk("truncated pkt_count", 512'(pkt_count), 512'(pkt_exp));

        // One-cycle reset in the middle of a packet.
        push_pkt(40, 5, 4, 1'b1);
        drive_fifo();
        repeat (3) step();
        reset = 1'b1;
        @(negedge clk);
        chk("midreset rd_en", 512'(rd_en), 512'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        fifo.delete();
        drive_fifo();
        beats.delete();
        prev_stall = 1'b0;
        check_idle_outputs("midreset");

        push_pkt(41, 3, 16, 1'b1);
        drive_fifo();
        exp_pkt(41, 64);
        drain("post_reset", 1'b0);
        compare_beats("post_reset");
        chk("post_reset pkt_count", 512'(pkt_count), 512'(1));
        chk("post_reset err_count", 512'(err_count), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
